astar_resp_unpacker: RTL and testbench



---
 rtl/astar_resp_unpacker_pkg.sv | 32 +++
 rtl/astar_desc_fifo.sv | 61 ++++++
 rtl/astar_resp_unpacker.sv | 127 ++++++++++++
 tb/tb_astar_resp_unpacker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/astar_resp_unpacker_pkg.sv
// Shared types for the A* read-response unpacker: task fields and the
// per-burst read descriptor held while its beats stream back.
`timescale 1ns/1ps
package astar_resp_unpacker_pkg;

    typedef logic [31:0] task_t;
    typedef logic [3:0]  subtype_t;
    typedef logic [5:0]  cq_slice_slot_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  byte_t;

    // arsize code for 32-bit elements; every other code passes the beat through whole
    localparam logic [2:0] ArSize32 = 3'd2;

    typedef struct packed {
        task_t          tsk;
        subtype_t       subtype;
        cq_slice_slot_t cq_slot;
        logic [7:0]     arlen;
        logic [2:0]     arsize;
        logic           mark_last;
    } astar_rd_desc_t;

    // Narrow a raw beat to the element width named by arsize
    function automatic data_t size_data(input logic [2:0] arsize, input data_t raw);
        if (arsize == ArSize32) begin
            return {32'b0, raw[31:0]};
        end
        return raw;
    endfunction

endpackage

// File: rtl/astar_desc_fifo.sv
// First-word fall-through FIFO holding outstanding read descriptors.
// Push while full and pop while empty are ignored.
`timescale 1ns/1ps
module astar_desc_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   size
);

    localparam int unsigned Depth = 2 ** LOG_DEPTH;

    logic [WIDTH-1:0]     mem [Depth];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (size == (LOG_DEPTH + 1)'(Depth));
    assign empty   = (size == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   size <= size + (LOG_DEPTH + 1)'(1);
                2'b01:   size <= size - (LOG_DEPTH + 1)'(1);
                default: size <= size;
            endcase
        end
    end

endmodule

// File: rtl/astar_resp_unpacker.sv
// Turns in-order read-response beats into one task per beat, tagging each
// with its beat index and flagging the final beat of bursts that asked for it.
`timescale 1ns/1ps
module astar_resp_unpacker
    import astar_resp_unpacker_pkg::*;
#(
    parameter int          TILE_ID   = 0,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  task_t                req_task,
    input  subtype_t             req_subtype,
    input  cq_slice_slot_t       req_cq_slot,
    input  logic [7:0]           req_arlen,
    input  logic [2:0]           req_arsize,
    input  logic                 req_mark_last,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [63:0]          rdata,
    input  logic                 rlast,
    output logic                 out_valid,
    input  logic                 out_ready,
    output task_t                out_task,
    output subtype_t             out_subtype,
    output data_t                out_data,
    output byte_t                out_word_id,
    output cq_slice_slot_t       out_cq_slot,
    output logic                 out_last,
    output logic                 err_rlast,
    output logic [LOG_DEPTH:0]   occupancy
);

    // The tile index only labels instances; reject nonsense at elaboration
    if (TILE_ID < 0) begin : g_bad_tile_id
        $error("astar_resp_unpacker: TILE_ID must be non-negative");
    end

    astar_rd_desc_t req_desc;
    astar_rd_desc_t head;
    logic           full;
    logic           empty;
    logic           push;
    logic           accept;
    logic           last_beat;
    logic           pop;
    logic [7:0]     beat_idx;

    assign req_desc = '{
        tsk:       req_task,
        subtype:   req_subtype,
        cq_slot:   req_cq_slot,
        arlen:     req_arlen,
        arsize:    req_arsize,
        mark_last: req_mark_last
    };

    // Ready depends only on the registered fill level, so a same-cycle pop
    // cannot unblock a full FIFO.
    assign req_ready = ~full;
    assign push      = req_valid & req_ready;

    // Beats need a descriptor already at the head; one pushed this cycle is not visible yet
    assign rready    = ~empty & (~out_valid | out_ready);
    assign accept    = rvalid & rready;
    assign last_beat = (beat_idx == head.arlen);
    assign pop       = accept & last_beat;

    astar_desc_fifo #(
        .WIDTH     ($bits(astar_rd_desc_t)),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req_desc),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .size  (occupancy)
    );

    // Beat counter for the head burst; arlen decides the end, rlast is only checked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx <= '0;
        end else if (accept) begin
            beat_idx <= last_beat ? 8'd0 : beat_idx + 8'd1;
        end
    end

    // Sticky flag when memory's rlast disagrees with the counted burst length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_rlast <= 1'b0;
        end else if (accept && (rlast != last_beat)) begin
            err_rlast <= 1'b1;
        end
    end

    // Single-entry output register; a new beat replaces a draining one without a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_task    <= '0;
            out_subtype <= '0;
            out_data    <= '0;
            out_word_id <= '0;
            out_cq_slot <= '0;
            out_last    <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_task    <= head.tsk;
            out_subtype <= head.subtype;
            out_data    <= size_data(head.arsize, rdata);
            out_word_id <= beat_idx;
            out_cq_slot <= head.cq_slot;
            out_last    <= head.mark_last & last_beat;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_astar_resp_unpacker.sv
// Randomized and directed bench for astar_resp_unpacker against a queue-based model.
`timescale 1ns/1ps
module tb_astar_resp_unpacker;
    import astar_resp_unpacker_pkg::*;

    localparam int unsigned LogDepth = 4;
    localparam int          Depth    = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    task_t              req_task;
    subtype_t           req_subtype;
    cq_slice_slot_t     req_cq_slot;
    logic [7:0]         req_arlen;
    logic [2:0]         req_arsize;
    logic               req_mark_last;
    logic               rvalid;
    logic               rready;
    logic [63:0]        rdata;
    logic               rlast;
    logic               out_valid;
    logic               out_ready;
    task_t              out_task;
    subtype_t           out_subtype;
    data_t              out_data;
    byte_t              out_word_id;
    cq_slice_slot_t     out_cq_slot;
    logic               out_last;
    logic               err_rlast;
    logic [LogDepth:0]  occupancy;

    always #5 clk = ~clk;

    astar_resp_unpacker #(
        .TILE_ID   (0),
        .LOG_DEPTH (LogDepth)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_task      (req_task),
        .req_subtype   (req_subtype),
        .req_cq_slot   (req_cq_slot),
        .req_arlen     (req_arlen),
        .req_arsize    (req_arsize),
        .req_mark_last (req_mark_last),
        .rvalid        (rvalid),
        .rready        (rready),
        .rdata         (rdata),
        .rlast         (rlast),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_task      (out_task),
        .out_subtype   (out_subtype),
        .out_data      (out_data),
        .out_word_id   (out_word_id),
        .out_cq_slot   (out_cq_slot),
        .out_last      (out_last),
        .err_rlast     (err_rlast),
        .occupancy     (occupancy)
    );

    typedef struct {
        task_t          tsk;
        subtype_t       st;
        cq_slice_slot_t slot;
        int             arlen;
        int             arsize;
        bit             mark_last;
    } desc_s;

    typedef struct {
        task_t          tsk;
        subtype_t       st;
        cq_slice_slot_t slot;
        logic [63:0]    data;
        int             word_id;
        bit             last;
    } out_s;

    // Reference model: outstanding bursts, pending outputs, beats taken from head burst
    desc_s desc_q[$];
    out_s  exp_q[$];
    int    beat_cnt;
    bit    exp_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_last();
        return desc_q.size() > 0 && beat_cnt == desc_q[0].arlen;
    endfunction

    task automatic model_clear();
        desc_q.delete();
        exp_q.delete();
        beat_cnt = 0;
        exp_err  = 1'b0;
    endtask

    task automatic set_desc(input int arlen, input int arsize, input bit ml);
        req_task      = $urandom;
        req_subtype   = subtype_t'($urandom);
        req_cq_slot   = cq_slice_slot_t'($urandom);
        req_arlen     = 8'(arlen);
        req_arsize    = 3'(arsize);
        req_mark_last = ml;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        out_ready = 1'b1;
    endtask

    // One cycle: called at a negedge with inputs driven; checks, then advances the model
    task automatic step();
        bit    push, acc, drain;
        desc_s d;
        out_s  o;
        #1;
        check_eq("req_ready", req_ready, desc_q.size() < Depth);
        check_eq("occupancy", occupancy, desc_q.size());
        check_eq("rready", rready, desc_q.size() > 0 && (exp_q.size() == 0 || out_ready));
        check_eq("out_valid", out_valid, exp_q.size() > 0);
        check_eq("err_rlast", err_rlast, exp_err);
        if (exp_q.size() > 0) begin
            check_eq("out_task", out_task, exp_q[0].tsk);
            check_eq("out_subtype", out_subtype, exp_q[0].st);
            check_eq("out_cq_slot", out_cq_slot, exp_q[0].slot);
            check_eq("out_data", out_data, exp_q[0].data);
            check_eq("out_word_id", out_word_id, exp_q[0].word_id);
            check_eq("out_last", out_last, exp_q[0].last);
        end
        push  = req_valid && desc_q.size() < Depth;
        acc   = rvalid && desc_q.size() > 0 && (exp_q.size() == 0 || out_ready);
        drain = exp_q.size() > 0 && out_ready;
        @(posedge clk);
        if (drain) exp_q.pop_front();
        if (acc) begin
            d         = desc_q[0];
            o.tsk     = d.tsk;
            o.st      = d.st;
            o.slot    = d.slot;
            o.data    = (d.arsize == 2) ? {32'h0, rdata[31:0]} : rdata;
            o.word_id = beat_cnt;
            o.last    = d.mark_last && beat_cnt == d.arlen;
            if (rlast != (beat_cnt == d.arlen)) exp_err = 1'b1;
            if (beat_cnt == d.arlen) begin
                void'(desc_q.pop_front());
                beat_cnt = 0;
            end else begin
                beat_cnt++;
            end
            exp_q.push_back(o);
        end
        if (push) begin
            d.tsk       = req_task;
            d.st        = req_subtype;
            d.slot      = req_cq_slot;
            d.arlen     = int'(req_arlen);
            d.arsize    = int'(req_arsize);
            d.mark_last = req_mark_last;
            desc_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic push_desc(input int arlen, input int arsize, input bit ml);
        drive_idle();
        req_valid = 1'b1;
        set_desc(arlen, arsize, ml);
        step();
    endtask

    task automatic beat(input logic [63:0] data, input bit last, input bit ordy);
        drive_idle();
        rvalid    = 1'b1;
        rdata     = data;
        rlast     = last;
        out_ready = ordy;
        step();
    endtask

    // Feed well-formed beats until the model holds nothing; bounded
    task automatic drain_all();
        for (int i = 0; i < 400; i++) begin
            if (desc_q.size() == 0 && exp_q.size() == 0) break;
            beat({$urandom, $urandom}, model_last(), 1'b1);
        end
        check_eq("drain_done", desc_q.size() + exp_q.size(), 0);
    endtask

    task automatic check_reset_values();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_word_id", out_word_id, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_task", out_task, 0);
        check_eq("rst_err_rlast", err_rlast, 0);
        check_eq("rst_occupancy", occupancy, 0);
    endtask

    int wid[5] = '{0, 1, 0, 1, 2};

    initial begin
        rst = 1'b1;
        drive_idle();
        set_desc(0, 3, 1'b0);
        rdata = '0;
        model_clear();
        #2;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single beat, 64-bit, flagged last
        push_desc(0, 3, 1'b1);
        beat(64'h0000_0005_0000_0003, 1'b1, 1'b1);
        check_eq("single_word_id", out_word_id, 0);
        check_eq("single_data", out_data, 64'h0000_0005_0000_0003);
        check_eq("single_last", out_last, 1);
        drive_idle();
        step();
        check_eq("single_occ", occupancy, 0);

        // 32-bit burst of four
        push_desc(3, 2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            beat(64'hFFFF_FFFF_0000_0000 | 64'(k), k == 3, 1'b1);
            check_eq("b32_word_id", out_word_id, k);
            check_eq("b32_data", out_data, 64'(k));
            check_eq("b32_last", out_last, 0);
        end
        drive_idle();
        step();

        // Back-to-back bursts, one output per cycle
        push_desc(1, 3, 1'b1);
        push_desc(2, 3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            beat({$urandom, $urandom}, model_last(), 1'b1);
            check_eq("b2b_valid", out_valid, 1);
            check_eq("b2b_word_id", out_word_id, wid[k]);
        end
        drive_idle();
        step();

        // Backpressure mid-burst
        push_desc(3, 3, 1'b0);
        beat(64'h1111_2222_3333_4444, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            beat({$urandom, $urandom}, model_last(), 1'b0);
            check_eq("bp_hold_word", out_word_id, 0);
            check_eq("bp_hold_data", out_data, 64'h1111_2222_3333_4444);
        end
        drain_all();

        // Full FIFO
        for (int k = 0; k < Depth; k++) push_desc(0, 3, 1'b0);
        check_eq("full_occ", occupancy, 16);
        check_eq("full_ready", req_ready, 0);
        drive_idle();
        req_valid = 1'b1;
        set_desc(0, 3, 1'b0);
        rvalid = 1'b1;
        rdata  = {$urandom, $urandom};
        rlast  = 1'b1;
        step();
        check_eq("full_ready_after_pop", req_ready, 1);
        drain_all();

        // rlast error does not cut the burst short
        push_desc(3, 3, 1'b1);
        for (int k = 0; k < 4; k++) beat({$urandom, $urandom}, (k == 1) || (k == 3), 1'b1);
        check_eq("err_set", err_rlast, 1);
        drive_idle();
        step();

        // Asynchronous reset mid-burst with an output pending
        push_desc(7, 3, 1'b1);
        beat({$urandom, $urandom}, 1'b0, 1'b1);
        beat({$urandom, $urandom}, 1'b0, 1'b0);
        drive_idle();
        rst = 1'b1;
        #1;
        check_reset_values();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Random traffic
        for (int c = 0; c < 2500; c++) begin
            req_valid = ($urandom % 3) == 0;
            set_desc($urandom % 4, ($urandom % 2) ? 2 : ($urandom % 8), 1'($urandom % 2));
            rvalid    = ($urandom % 4) != 0;
            rdata     = {$urandom, $urandom};
            rlast     = model_last() ^ (($urandom % 60) == 0);
            out_ready = ($urandom % 4) != 0;
            step();
        end
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
